player_ctrl: RTL and testbench
==============================

Name: player_ctrl

Overview:
- Per-player movement and bomb-drop controller for the tile game.
- Consumes held-key levels from the keyboard decoder and the walkability vector produced by the pixel/map generator.
- Produces the player's tile coordinates and a single-cycle attack (bomb-drop) pulse, which feed back into the pixel/map generator.
- One instance per player, A and B.

Parameters:
- HTILES, 10, horizontal tile count (columns 0..HTILES-1)
- VTILES, 6, vertical tile count (rows 0..VTILES-1)
- START_H, 0, column after reset
- START_V, 0, row after reset
- REPEAT_FIRST, 25000000, cycles a direction key is held before the first auto-repeat step
- REPEAT_NEXT, 12500000, cycles between later auto-repeat steps
- BOMB_CD, 134217728, cooldown in cycles after a bomb drop
- CNT_W, 28, width of the repeat and cooldown counters; must hold the largest of the three cycle parameters

Ports:
- clk, input, 1, system clock
- rst, input, 1, reset; synchronous, active-high
- key_up, input, 1, level; up key held
- key_down, input, 1, level; down key held
- key_left, input, 1, level; left key held
- key_right, input, 1, level; right key held
- key_bomb, input, 1, level; bomb key held
- freeze, input, 1, level; game over or pause
- walk_able, input, HTILES*VTILES+1, bit v*HTILES+h = 1 when tile (h,v) is enterable; MSB unused
- cur_h, output, 4, current column (registered)
- cur_v, output, 4, current row (registered)
- atk, output, 1, one-cycle bomb-drop pulse (registered)
- moved, output, 1, one-cycle pulse when the position changed this cycle (registered)

Behaviour:
- Reset values:
  - cur_h=START_H, cur_v=START_V
  - atk=0, moved=0
  - FSM=IDLE, repeat counter=0, cooldown=0
  - bomb_q=1, so a bomb key held through reset does not fire.
- Direction select (combinational), fixed priority UP > DOWN > LEFT > RIGHT; dir=NONE when no key is held.
- Step attempt:
  - Target = cur ±1 on the chosen axis.
  - Rejected if the target is out of range: cur_v==0 for UP, cur_v==VTILES-1 for DOWN, cur_h==0 for LEFT, cur_h==HTILES-1 for RIGHT.
  - Rejected if walk_able[target_v*HTILES+target_h]==0.
  - Accepted: cur_* updates at the next edge and moved=1 for that one cycle.
  - A rejected attempt still consumes its repeat slot; there is no retry until the next slot.
  - Latency: key seen at edge k → new cur_* and moved visible in cycle k+1.
- FSM:
  - IDLE: dir!=NONE → attempt step, load counter=REPEAT_FIRST-1, go to HOLD.
  - HOLD, dir==NONE → IDLE.
  - HOLD, dir differs from latched dir → attempt step in the new dir, reload REPEAT_FIRST-1, latch the new dir.
  - HOLD, counter==0 → attempt step, reload REPEAT_NEXT-1.
  - HOLD, otherwise → decrement counter.
- Bomb:
  - Rising edge on key_bomb (key_bomb & ~bomb_q) with cooldown==0 and freeze==0 → atk=1 for exactly one cycle, cooldown=BOMB_CD-1.
  - Cooldown decrements to 0 and saturates.
  - An edge that arrives during cooldown is discarded, not queued.
- Bomb/move collision:
  - When a bomb fires at edge k, any step attempt at edge k is suppressed. The FSM state and counter hold, and the attempt is retried at edge k+1.
  - This guarantees atk is presented with the pre-move cur_*.
- freeze=1:
  - cur_* held; atk=0, moved=0; FSM forced to IDLE.
  - Cooldown keeps counting; bomb_q keeps tracking key_bomb.
- rst asserted mid-operation returns all state to reset values at that edge, with no pending step or bomb.

Decomposition:
- Shared package game_pkg:
  - DIR_NONE/UP/DOWN/LEFT/RIGHT (3-bit) encodings
  - HTILES/VTILES defaults
  - tile_idx(h,v) function
- pixel_gen and player_ctrl both use game_pkg so the walk_able indexing matches.
- One sub-module, key_repeat: dir input → step strobe, encapsulating IDLE/HOLD and the repeat counter.
- Bounds checking, walk_able lookup and the bomb cooldown stay in the top module.

Test Plan:
All scenarios use REPEAT_FIRST=4, REPEAT_NEXT=2, BOMB_CD=8, START=(0,0), walk_able all 1 unless stated.
1. Hold key_right 9 cycles → cur_h goes 0→1 at cycle 1, →2 at cycle 5, →3 at cycle 7, →4 at cycle 9; moved pulses only on those cycles.
2. Start (0,0), press key_up or key_left → cur unchanged, moved=0; walk_able bit 1 cleared, press right → cur_h stays 0.
3. Hold key_up and key_right at (3,3) → only row decrements to (3,2); release up while right stays held → cur_h=4 on the next cycle (direction change counts as a fresh first step).
4. Pulse key_bomb at (2,2) → atk=1 for one cycle; second press 3 cycles later → no atk; press after 8 cycles → atk=1.
5. key_bomb and key_down rise in the same cycle at (1,1) → atk=1 with cur=(1,1); next cycle cur=(1,2) with moved=1.
6. Hold key_bomb through rst deassertion → no atk. Assert freeze while holding right → cur frozen, atk=0. Assert rst mid-HOLD → cur=(START_H,START_V) on the next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared tile-game definitions: direction encodings, map defaults, and the
// walk_able bit index helper, so the pixel generator and the player controllers
// agree on the tile ordering.
package game_pkg;

  localparam int HTILES_DEF = 10;
  localparam int VTILES_DEF = 6;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  typedef enum logic {
    KR_IDLE = 1'b0,
    KR_HOLD = 1'b1
  } kr_state_e;

  // Row-major tile index: bit v*htiles+h of walk_able describes tile (h,v).
  function automatic int tile_idx(input int h, input int v, input int htiles = HTILES_DEF);
    return v * htiles + h;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Key auto-repeat: turns a held direction into step strobes. The first strobe
// fires on the press, the next after REPEAT_FIRST cycles, then every
// REPEAT_NEXT cycles. A direction change restarts the sequence.
// stall_i freezes the whole machine for one edge (used when a bomb drop wins
// the edge); clear_i forces it back to IDLE.
module key_repeat
  import game_pkg::*;
#(
  parameter int REPEAT_FIRST = 25000000,
  parameter int REPEAT_NEXT  = 12500000,
  parameter int CNT_W        = 28
) (
  input  logic clk,
  input  logic rst,
  input  dir_e dir_i,
  input  logic stall_i,
  input  logic clear_i,
  output logic step_o
);

  kr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             ldir_q, ldir_d;

  // State, repeat counter and latched direction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= KR_IDLE;
      cnt_q   <= '0;
      ldir_q  <= DIR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ldir_q  <= ldir_d;
    end
  end

  // Next-state and step strobe; a stall holds everything and suppresses the step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ldir_d  = ldir_q;
    step_o  = 1'b0;
    if (clear_i) begin
      state_d = KR_IDLE;
      cnt_d   = '0;
      ldir_d  = DIR_NONE;
    end else if (!stall_i) begin
      case (state_q)
        KR_IDLE: begin
          if (dir_i != DIR_NONE) begin
            step_o  = 1'b1;
            cnt_d   = CNT_W'(REPEAT_FIRST - 1);
            ldir_d  = dir_i;
            state_d = KR_HOLD;
          end
        end
        KR_HOLD: begin
          if (dir_i == DIR_NONE) begin
            state_d = KR_IDLE;
            cnt_d   = '0;
          end else if (dir_i != ldir_q) begin
            step_o = 1'b1;
            cnt_d  = CNT_W'(REPEAT_FIRST - 1);
            ldir_d = dir_i;
          end else if (cnt_q == '0) begin
            step_o = 1'b1;
            cnt_d  = CNT_W'(REPEAT_NEXT - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = KR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// Per-player movement and bomb-drop controller. Turns held keys into tile
// steps (bounds- and walkability-checked) and rising bomb-key edges into a
// one-cycle atk pulse with cooldown. A bomb firing takes the edge, so atk is
// always presented with the pre-move position.
module player_ctrl
  import game_pkg::*;
#(
  parameter int HTILES       = HTILES_DEF,
  parameter int VTILES       = VTILES_DEF,
  parameter int START_H      = 0,
  parameter int START_V      = 0,
  parameter int REPEAT_FIRST = 25000000,
  parameter int REPEAT_NEXT  = 12500000,
  parameter int BOMB_CD      = 134217728,
  parameter int CNT_W        = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_up,
  input  logic                     key_down,
  input  logic                     key_left,
  input  logic                     key_right,
  input  logic                     key_bomb,
  input  logic                     freeze,
  input  logic [HTILES*VTILES:0]   walk_able,
  output logic [3:0]               cur_h,
  output logic [3:0]               cur_v,
  output logic                     atk,
  output logic                     moved
);

  localparam int IDX_W = $clog2(HTILES * VTILES + 1);

  logic [3:0]       cur_h_q, cur_v_q;
  logic             atk_q, moved_q, bomb_q;
  logic [CNT_W-1:0] cd_q;

  dir_e             dir;
  logic             fire, step, in_range, accept;
  logic [3:0]       tgt_h, tgt_v;
  logic [IDX_W-1:0] idx;

  // Fixed-priority direction select: UP > DOWN > LEFT > RIGHT.
  always_comb begin
    dir = DIR_NONE;
    if (key_up)         dir = DIR_UP;
    else if (key_down)  dir = DIR_DOWN;
    else if (key_left)  dir = DIR_LEFT;
    else if (key_right) dir = DIR_RIGHT;
  end

  assign fire = key_bomb & ~bomb_q & (cd_q == '0) & ~freeze;

  key_repeat #(
    .REPEAT_FIRST (REPEAT_FIRST),
    .REPEAT_NEXT  (REPEAT_NEXT),
    .CNT_W        (CNT_W)
  ) u_rep (
    .clk     (clk),
    .rst     (rst),
    .dir_i   (dir),
    .stall_i (fire),
    .clear_i (freeze),
    .step_o  (step)
  );

  // Neighbour tile in the chosen direction and whether it lies on the map.
  always_comb begin
    tgt_h    = cur_h_q;
    tgt_v    = cur_v_q;
    in_range = 1'b0;
    case (dir)
      DIR_UP: begin
        in_range = (cur_v_q != 4'd0);
        tgt_v    = cur_v_q - 4'd1;
      end
      DIR_DOWN: begin
        in_range = (cur_v_q != 4'(VTILES - 1));
        tgt_v    = cur_v_q + 4'd1;
      end
      DIR_LEFT: begin
        in_range = (cur_h_q != 4'd0);
        tgt_h    = cur_h_q - 4'd1;
      end
      DIR_RIGHT: begin
        in_range = (cur_h_q != 4'(HTILES - 1));
        tgt_h    = cur_h_q + 4'd1;
      end
      default: ;
    endcase
  end

  assign idx    = IDX_W'(tile_idx(int'(tgt_h), int'(tgt_v), HTILES));
  assign accept = step & in_range & walk_able[idx];

  // Position, pulse outputs, bomb edge tracking and cooldown.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_h_q <= 4'(START_H);
      cur_v_q <= 4'(START_V);
      atk_q   <= 1'b0;
      moved_q <= 1'b0;
      bomb_q  <= 1'b1;
      cd_q    <= '0;
    end else begin
      bomb_q  <= key_bomb;
      atk_q   <= fire;
      moved_q <= accept;
      if (fire)              cd_q <= CNT_W'(BOMB_CD - 1);
      else if (cd_q != '0)   cd_q <= cd_q - CNT_W'(1);
      if (accept) begin
        cur_h_q <= tgt_h;
        cur_v_q <= tgt_v;
      end
    end
  end

  assign cur_h = cur_h_q;
  assign cur_v = cur_v_q;
  assign atk   = atk_q;
  assign moved = moved_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed scenarios plus a randomized soak, with every
// cycle compared against a behavioural model that counts hold time per
// direction instead of tracking a state machine.
module tb_player_ctrl;

  localparam int HT = 10;
  localparam int VT = 6;
  localparam int RF = 4;
  localparam int RN = 2;
  localparam int CD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ku = 1'b0, kd = 1'b0, kl = 1'b0, kr = 1'b0, kb = 1'b0, frz = 1'b0;
  logic [HT*VT:0] wa;
  logic [3:0] cur_h, cur_v;
  logic atk, moved;

  int checks = 0;
  int errors = 0;

  // model state
  int m_h, m_v, m_atk, m_mov, m_cd, m_bq, m_dir, m_n;

  int t1h[9] = '{1, 1, 1, 1, 2, 2, 3, 3, 4};
  int t1m[9] = '{1, 0, 0, 0, 1, 0, 1, 0, 1};

  player_ctrl #(
    .HTILES(HT), .VTILES(VT), .START_H(0), .START_V(0),
    .REPEAT_FIRST(RF), .REPEAT_NEXT(RN), .BOMB_CD(CD), .CNT_W(28)
  ) dut (
    .clk(clk), .rst(rst),
    .key_up(ku), .key_down(kd), .key_left(kl), .key_right(kr),
    .key_bomb(kb), .freeze(frz), .walk_able(wa),
    .cur_h(cur_h), .cur_v(cur_v), .atk(atk), .moved(moved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs held at that edge.
  task automatic model_edge();
    int d, th, tv;
    bit fire, slot, ok;
    if (rst) begin
      m_h = 0; m_v = 0; m_atk = 0; m_mov = 0;
      m_cd = 0; m_bq = 1; m_dir = 0; m_n = 0;
      return;
    end
    fire = kb && !m_bq && (m_cd == 0) && !frz;
    m_bq = kb;
    if (fire) m_cd = CD - 1;
    else if (m_cd > 0) m_cd--;
    m_atk = fire;
    m_mov = 0;
    d = ku ? 1 : kd ? 2 : kl ? 3 : kr ? 4 : 0;
    if (frz) m_dir = 0;
    else if (!fire) begin
      slot = 0;
      if (d == 0) m_dir = 0;
      else if (d != m_dir) begin
        slot = 1; m_dir = d; m_n = 1;
      end else begin
        slot = (m_n >= RF) && (((m_n - RF) % RN) == 0);
        m_n++;
      end
      if (slot) begin
        th = m_h; tv = m_v;
        case (d)
          1: tv--;
          2: tv++;
          3: th--;
          default: th++;
        endcase
        ok = (th >= 0) && (th < HT) && (tv >= 0) && (tv < VT) && wa[tv*HT+th];
        if (ok) begin m_h = th; m_v = tv; m_mov = 1; end
      end
    end
  endtask

  // Advance one cycle and compare all outputs with the model.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("cur_h", cur_h, m_h);
    chk("cur_v", cur_v, m_v);
    chk("atk", atk, m_atk);
    chk("moved", moved, m_mov);
  endtask

  task automatic keys(input bit u, input bit dn, input bit l, input bit r);
    ku = u; kd = dn; kl = l; kr = r;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  // Walk from the current tile to (h,v) by holding down then right.
  task automatic goto(input int h, input int v);
    keys(0, 0, 0, 0); cyc();
    for (int i = 0; i < 60 && m_v < v; i++) begin kd = 1'b1; cyc(); end
    keys(0, 0, 0, 0); cyc();
    for (int i = 0; i < 60 && m_h < h; i++) begin kr = 1'b1; cyc(); end
    keys(0, 0, 0, 0); cyc();
    chk("goto_h", cur_h, h);
    chk("goto_v", cur_v, v);
  endtask

  initial begin
    wa = '1;

    // reset with bomb key held through deassertion
    rst = 1'b1; kb = 1'b1;
    run(2);
    chk("rst_h", cur_h, 0);
    chk("rst_v", cur_v, 0);
    chk("rst_atk", atk, 0);
    chk("rst_moved", moved, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin cyc(); chk("bomb_thru_rst", atk, 0); end
    kb = 1'b0; cyc();

    // 1: auto-repeat cadence
    keys(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("t1_h", cur_h, t1h[i]);
      chk("t1_moved", moved, t1m[i]);
    end
    keys(0, 0, 0, 0); cyc();

    // 2: edges of the map and blocked tiles
    do_reset();
    keys(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin cyc(); chk("t2_up_v", cur_v, 0); chk("t2_up_mv", moved, 0); end
    keys(0, 0, 0, 0); cyc();
    keys(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin cyc(); chk("t2_lf_h", cur_h, 0); chk("t2_lf_mv", moved, 0); end
    keys(0, 0, 0, 0); cyc();
    wa[1] = 1'b0;
    keys(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin cyc(); chk("t2_wall_h", cur_h, 0); end
    wa = '1;
    keys(0, 0, 0, 0); cyc();

    // 3: priority and direction change
    do_reset();
    goto(3, 3);
    keys(1, 0, 0, 1); cyc();
    chk("t3_h", cur_h, 3); chk("t3_v", cur_v, 2); chk("t3_mv", moved, 1);
    keys(0, 0, 0, 1); cyc();
    chk("t3_chg_h", cur_h, 4); chk("t3_chg_v", cur_v, 2);
    keys(0, 0, 0, 0); cyc();

    // 4: bomb cooldown, discarded press
    do_reset();
    goto(2, 2);
    kb = 1'b1; cyc(); chk("t4_atk1", atk, 1);
    kb = 1'b0; cyc(); chk("t4_atk_once", atk, 0);
    cyc();
    kb = 1'b1; cyc(); chk("t4_cd_block", atk, 0);
    kb = 1'b0; run(4);
    kb = 1'b1; cyc(); chk("t4_atk2", atk, 1);
    kb = 1'b0; cyc();

    // 5: bomb and move collide
    do_reset();
    goto(1, 1);
    kb = 1'b1; kd = 1'b1; cyc();
    chk("t5_atk", atk, 1); chk("t5_h", cur_h, 1); chk("t5_v", cur_v, 1); chk("t5_mv0", moved, 0);
    cyc();
    chk("t5_atk0", atk, 0); chk("t5_v2", cur_v, 2); chk("t5_mv1", moved, 1);
    kb = 1'b0; keys(0, 0, 0, 0); cyc();

    // 6: freeze while holding right, bomb under freeze
    do_reset();
    keys(0, 0, 0, 1); run(2);
    frz = 1'b1;
    for (int i = 0; i < 6; i++) begin
      kb = (i == 2 || i == 3);
      cyc();
      chk("t6_frz_h", cur_h, 1); chk("t6_frz_atk", atk, 0); chk("t6_frz_mv", moved, 0);
    end
    frz = 1'b0; kb = 1'b0; keys(0, 0, 0, 0); cyc();

    // 6: reset mid-hold
    do_reset();
    keys(0, 0, 0, 1); run(6);
    chk("t6_pre_h", cur_h, 2);
    rst = 1'b1; cyc();
    chk("t6_rst_h", cur_h, 0); chk("t6_rst_v", cur_v, 0); chk("t6_rst_mv", moved, 0);
    rst = 1'b0; keys(0, 0, 0, 0); cyc();

    // randomized soak against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ku = ($urandom_range(0, 4) == 0);
        kd = ($urandom_range(0, 3) == 0);
        kl = ($urandom_range(0, 3) == 0);
        kr = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 5) == 0) kb = ~kb;
      if ($urandom_range(0, 39) == 0) frz = ~frz;
      rst = ($urandom_range(0, 499) == 0);
      if (i % 100 == 0)
        for (int j = 0; j <= HT*VT; j++) wa[j] = ($urandom_range(0, 6) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
